// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with dead time,
// leading-zero blanking and frame-aligned value updates.

module seven_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      default: seg_n = 7'b0001110;
    endcase
  end
endmodule

module seg7_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    digit_reg, digit_next;

  logic [15:0] active_value_reg, shadow_value_reg;
  logic [3:0]  active_dp_reg, shadow_dp_reg;
  logic        pending_reg;

  logic [3:0] an_reg, an_next;
  logic [6:0] seg_reg, seg_next;
  logic       dp_reg, dp_next;
  logic       frame_done_reg, frame_done_next;

  logic [3:0] zero_above;
  logic [3:0] nibble_sel;
  logic [6:0] dec_seg_n;
  logic       dp_sel;
  logic       show_lit;
  logic       boundary;

  // zero_above[k]: nibbles k..3 are all zero, so digit k is a leading zero
  assign zero_above[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lz
    assign zero_above[gi] = (active_value_reg[15:4*gi] == '0);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    digit_next = digit_reg;
    if (!enable) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      digit_next = 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          digit_next = 2'd0;
        end
        ST_BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = ST_SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_reg == SHOW_LAST) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
            digit_next = digit_reg + 2'd1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          digit_next = 2'd0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state. The active value only changes
  // on edges that lead into a dark cycle, so reading it here is glitch-free.
  always_comb begin
    nibble_sel = active_value_reg[3:0];
    case (digit_next)
      2'd1:    nibble_sel = active_value_reg[7:4];
      2'd2:    nibble_sel = active_value_reg[11:8];
      2'd3:    nibble_sel = active_value_reg[15:12];
      default: nibble_sel = active_value_reg[3:0];
    endcase
  end

  seven_seg u_seven_seg (
    .nibble (nibble_sel),
    .seg_n  (dec_seg_n)
  );

  always_comb begin
    dp_sel          = active_dp_reg[digit_next];
    show_lit        = (state_next == ST_SHOW) && !(lz_blank_en && zero_above[digit_next]);
    an_next         = show_lit ? ~(4'b0001 << digit_next) : 4'hF;
    seg_next        = show_lit ? dec_seg_n : 7'h7F;
    dp_next         = show_lit ? ~dp_sel : 1'b1;
    frame_done_next = (state_next == ST_SHOW) && (digit_next == 2'd3) && (cnt_next == SHOW_LAST);
  end

  assign boundary = frame_done_reg && enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      digit_reg        <= 2'd0;
      an_reg           <= 4'hF;
      seg_reg          <= 7'h7F;
      dp_reg           <= 1'b1;
      frame_done_reg   <= 1'b0;
      active_value_reg <= '0;
      active_dp_reg    <= '0;
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      pending_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      digit_reg      <= digit_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
      frame_done_reg <= frame_done_next;
      // Direct write when nothing is being scanned or at the frame edge;
      // otherwise park the value until the next boundary.
      if (load && (!enable || state_reg == ST_IDLE || boundary)) begin
        active_value_reg <= value_in;
        active_dp_reg    <= dp_in;
        pending_reg      <= 1'b0;
      end else if (load) begin
        shadow_value_reg <= value_in;
        shadow_dp_reg    <= dp_in;
        pending_reg      <= 1'b1;
      end else if (boundary && pending_reg) begin
        active_value_reg <= shadow_value_reg;
        active_dp_reg    <= shadow_dp_reg;
        pending_reg      <= 1'b0;
      end
    end
  end

  assign an_n       = an_reg;
  assign seg_n      = seg_reg;
  assign dp_n       = dp_reg;
  assign digit_idx  = digit_reg;
  assign frame_done = frame_done_reg;
endmodule
